// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register-specifier
// width, M-bus layout and the all-zero control words fed by the bubble mux.
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_FLUSH  = 2'd1,
        HZ_XSTALL = 2'd2
    } hz_state_t;

    // M control bus carried in BF1: {MemWrite, MemRead, Branch}
    localparam int M_W       = 3;
    localparam int M_MEMREAD = 1;
    localparam int EX_W      = 4;
    localparam int WB_W      = 2;

    // Control words selected into BF1 when a bubble is inserted
    localparam logic [M_W-1:0]  M_ZERO  = '0;
    localparam logic [EX_W-1:0] EX_ZERO = '0;
    localparam logic [WB_W-1:0] WB_ZERO = '0;

    // Flush counter width, enough for FLUSH_CYCLES up to 15
    localparam int FCNT_W = 4;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and hazard_ctrl.
// Optional perf counter ports appear only when HZ_PERF_CNT_EN is defined.
//
// Freeze handshake: extStall_req is a level request held by the requester
// for as long as the freeze is needed; extStall_ack is high on every cycle
// the freeze is actually in effect (from the cycle after the request is first
// seen) and drops in the same cycle the request is seen low. A request is
// never acknowledged while a flush is in progress.
interface hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int REG_W = pipe_pkg::REG_W
`ifdef HZ_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic             memRead_BF1;
    logic [REG_W-1:0] rt_BF1;
    logic [REG_W-1:0] rs_ID;
    logic [REG_W-1:0] rt_ID;
    logic             usesRt_ID;
    logic             branchTaken;
    logic             extStall_req;
    logic             extStall_ack;
    logic             pcWrite;
    logic             ifidWrite;
    logic             flush_IFID;
    logic             bubble_BF1;
    logic             en_BF1;
    hz_state_t        state;
`ifdef HZ_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;
`endif

    modport master (
        output memRead_BF1, rt_BF1, rs_ID, rt_ID, usesRt_ID, branchTaken, extStall_req,
        input  extStall_ack, pcWrite, ifidWrite, flush_IFID, bubble_BF1, en_BF1, state
`ifdef HZ_PERF_CNT_EN
        , input stallCnt, flushCnt
`endif
    );

    modport slave (
        input  memRead_BF1, rt_BF1, rs_ID, rt_ID, usesRt_ID, branchTaken, extStall_req,
        output extStall_ack, pcWrite, ifidWrite, flush_IFID, bubble_BF1, en_BF1, state
`ifdef HZ_PERF_CNT_EN
        , output stallCnt, flushCnt
`endif
    );

endinterface

// File: rtl/hazard_cmp.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// register a load in EX is about to write. Register 0 never hazards.
module hazard_cmp #(
    parameter int REG_W = pipe_pkg::REG_W
) (
    input  logic             memRead_BF1,
    input  logic [REG_W-1:0] rt_BF1,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             usesRt_ID,
    output logic             hazard_LU
);

    // Match on rs always, on rt only when the ID instruction actually reads it
    always_comb begin
        hazard_LU = memRead_BF1 && (rt_BF1 != '0) &&
                    ((rt_BF1 == rs_ID) || (usesRt_ID && (rt_BF1 == rt_ID)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for IF/ID and ID/EX (BF1): load-use stall,
// taken-branch flush and external freeze. Outputs are combinational from the
// registered state and the current inputs.
// Optional feature macro: HZ_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W        = pipe_pkg::REG_W,
    parameter int FLUSH_CYCLES = 1
`ifdef HZ_PERF_CNT_EN
    , parameter int CNT_W      = 16
`endif
) (
    input  logic          clk_HZ,
    input  logic          rst_HZ,
    hazard_ctrl_if.slave  hz
);

    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic              MULTI_FLUSH = (FLUSH_CYCLES > 1);

    hz_state_t         state_q, state_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;

    logic hazard_lu;
    logic run_like;
    logic branch_eff;
    logic pc_write, ifid_write, flush_ifid, bubble, en_bf1, ack;

    hazard_cmp #(.REG_W(REG_W)) u_cmp (
        .memRead_BF1 (hz.memRead_BF1),
        .rt_BF1      (hz.rt_BF1),
        .rs_ID       (hz.rs_ID),
        .rt_ID       (hz.rt_ID),
        .usesRt_ID   (hz.usesRt_ID),
        .hazard_LU   (hazard_lu)
    );

    // State, flush counter and pending-branch flag
    always_ff @(posedge clk_HZ) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
    end

    // Next state and outputs; a freeze that is ending behaves as a RUN cycle
    // in which a branch remembered during the freeze counts as taken now
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        flush_ifid = 1'b0;
        bubble     = 1'b0;
        en_bf1     = 1'b1;
        ack        = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        run_like   = 1'b0;
        branch_eff = hz.branchTaken;

        if (rst_HZ) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
            state_d    = HZ_RUN;
            cnt_d      = '0;
            pend_d     = 1'b0;
        end else begin
            case (state_q)
                HZ_FLUSH: begin
                    flush_ifid = 1'b1;
                    bubble     = 1'b1;
                    if (hz.branchTaken) begin
                        cnt_d   = FLUSH_LOAD;
                        state_d = MULTI_FLUSH ? HZ_FLUSH : HZ_RUN;
                    end else if (cnt_q <= FCNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = HZ_RUN;
                    end else begin
                        cnt_d = cnt_q - FCNT_W'(1);
                    end
                end
                HZ_XSTALL: begin
                    if (hz.extStall_req) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        en_bf1     = 1'b0;
                        ack        = 1'b1;
                        if (hz.branchTaken) pend_d = 1'b1;
                    end else begin
                        run_like   = 1'b1;
                        branch_eff = hz.branchTaken | pend_q;
                        pend_d     = 1'b0;
                    end
                end
                default: run_like = 1'b1;
            endcase

            if (run_like) begin
                if (branch_eff) begin
                    flush_ifid = 1'b1;
                    bubble     = 1'b1;
                    cnt_d      = FLUSH_LOAD;
                    state_d    = MULTI_FLUSH ? HZ_FLUSH : HZ_RUN;
                end else if (hz.extStall_req) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    en_bf1     = 1'b0;
                    state_d    = HZ_XSTALL;
                end else if (hazard_lu) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    bubble     = 1'b1;
                    state_d    = HZ_RUN;
                end else begin
                    state_d = HZ_RUN;
                end
            end
        end
    end

    assign hz.pcWrite      = pc_write;
    assign hz.ifidWrite    = ifid_write;
    assign hz.flush_IFID   = flush_ifid;
    assign hz.bubble_BF1   = bubble;
    assign hz.en_BF1       = en_bf1;
    assign hz.extStall_ack = ack;
    assign hz.state        = state_q;

`ifdef HZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating counts of frozen-PC cycles and flush cycles
    always_ff @(posedge clk_HZ) begin
        if (rst_HZ) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_ifid && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hz.stallCnt = stall_cnt_q;
    assign hz.flushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl built with FLUSH_CYCLES=3.
// Output vector layout: {pcWrite, ifidWrite, flush_IFID, bubble_BF1, en_BF1, extStall_ack}
module tb_hazard_ctrl;
    import pipe_pkg::*;

    localparam logic [5:0] O_RST   = 6'b000110;
    localparam logic [5:0] O_DEF   = 6'b110010;
    localparam logic [5:0] O_LU    = 6'b000110;
    localparam logic [5:0] O_FLUSH = 6'b111110;
    localparam logic [5:0] O_FRZ0  = 6'b000000;
    localparam logic [5:0] O_XST   = 6'b000001;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    hazard_ctrl_if #(.REG_W(5)) hz ();

    hazard_ctrl #(.FLUSH_CYCLES(3)) dut (
        .clk_HZ (clk),
        .rst_HZ (rst),
        .hz     (hz)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {hz.pcWrite, hz.ifidWrite, hz.flush_IFID, hz.bubble_BF1, hz.en_BF1, hz.extStall_ack};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge; new inputs are applied here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // sample combinational outputs mid-cycle
    task automatic chk_outs(input string tag, input logic [5:0] exp);
        #3;
        check(tag, {26'd0, outs()}, {26'd0, exp});
    endtask

    task automatic idle_inputs();
        hz.memRead_BF1  = 1'b0;
        hz.rt_BF1       = '0;
        hz.rs_ID        = '0;
        hz.rt_ID        = '0;
        hz.usesRt_ID    = 1'b0;
        hz.branchTaken  = 1'b0;
        hz.extStall_req = 1'b0;
    endtask

    task automatic drive_lu(input logic mr, input logic [4:0] rtb, input logic [4:0] rs,
                            input logic [4:0] rt, input logic use_rt);
        hz.memRead_BF1 = mr;
        hz.rt_BF1      = rtb;
        hz.rs_ID       = rs;
        hz.rt_ID       = rt;
        hz.usesRt_ID   = use_rt;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();

        // reset dominates a taken branch
        rst = 1'b1;
        hz.branchTaken = 1'b1;
        cyc(); chk_outs("rst_c1", O_RST);
        cyc(); chk_outs("rst_c2", O_RST);
        cyc(); rst = 1'b0; idle_inputs();
        chk_outs("post_rst_def", O_DEF);
        check("post_rst_state", {30'd0, hz.state}, {30'd0, HZ_RUN});

        // load-use on rs: one stall cycle, then the bubble clears memRead
        cyc(); drive_lu(1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        chk_outs("lu_rs_stall", O_LU);
        cyc(); hz.memRead_BF1 = 1'b0;
        chk_outs("lu_rs_release", O_DEF);
        cyc(); drive_lu(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        chk_outs("lu_r0_none", O_DEF);
        cyc(); drive_lu(1'b1, 5'd8, 5'd3, 5'd8, 1'b0);
        chk_outs("lu_rt_unused", O_DEF);
        cyc(); drive_lu(1'b1, 5'd8, 5'd3, 5'd8, 1'b1);
        chk_outs("lu_rt_used", O_LU);
        cyc(); drive_lu(1'b0, 5'd8, 5'd8, 5'd8, 1'b1);
        chk_outs("lu_no_load", O_DEF);

        // branch flush for 3 cycles, hazard held throughout is ignored
        cyc(); drive_lu(1'b1, 5'd8, 5'd8, 5'd0, 1'b0); hz.branchTaken = 1'b1;
        chk_outs("br_f1", O_FLUSH);
        cyc(); hz.branchTaken = 1'b0;
        chk_outs("br_f2", O_FLUSH);
        check("br_state", {30'd0, hz.state}, {30'd0, HZ_FLUSH});
        cyc(); chk_outs("br_f3", O_FLUSH);
        cyc(); chk_outs("br_after_lu", O_LU);
        cyc(); idle_inputs();
        chk_outs("br_done", O_DEF);

        // external freeze for 4 cycles
        cyc(); hz.extStall_req = 1'b1;
        chk_outs("frz_c1", O_FRZ0);
        for (int i = 2; i <= 4; i++) begin
            cyc(); chk_outs($sformatf("frz_c%0d", i), O_XST);
        end
        check("frz_state", {30'd0, hz.state}, {30'd0, HZ_XSTALL});
        cyc(); hz.extStall_req = 1'b0;
        chk_outs("frz_c5", O_DEF);

        // branch during freeze is held until the freeze ends
        cyc(); hz.extStall_req = 1'b1;
        chk_outs("bf_c1", O_FRZ0);
        cyc(); hz.branchTaken = 1'b1;
        chk_outs("bf_c2", O_XST);
        cyc(); hz.branchTaken = 1'b0;
        chk_outs("bf_c3", O_XST);
        cyc(); hz.extStall_req = 1'b0;
        chk_outs("bf_exit_flush", O_FLUSH);
        cyc(); chk_outs("bf_f2", O_FLUSH);
        cyc(); chk_outs("bf_f3", O_FLUSH);
        cyc(); chk_outs("bf_done", O_DEF);

        // branch and freeze together: flush first, then freeze
        cyc(); hz.branchTaken = 1'b1; hz.extStall_req = 1'b1;
        chk_outs("bs_f1", O_FLUSH);
        cyc(); hz.branchTaken = 1'b0;
        chk_outs("bs_f2", O_FLUSH);
        cyc(); chk_outs("bs_f3", O_FLUSH);
        cyc(); chk_outs("bs_frz1", O_FRZ0);
        cyc(); chk_outs("bs_frz2", O_XST);
        cyc(); hz.extStall_req = 1'b0;
        chk_outs("bs_done", O_DEF);

        // reset in the middle of a freeze
        cyc(); hz.extStall_req = 1'b1;
        chk_outs("rf_c1", O_FRZ0);
        cyc(); chk_outs("rf_c2", O_XST);
        cyc(); rst = 1'b1;
        chk_outs("rf_rst", O_RST);
        cyc(); rst = 1'b0; hz.extStall_req = 1'b0;
        chk_outs("rf_def", O_DEF);
        check("rf_state", {30'd0, hz.state}, {30'd0, HZ_RUN});

`ifdef HZ_PERF_CNT_EN
        // two load-use stalls plus a 4-cycle freeze since the last reset
        for (int k = 0; k < 2; k++) begin
            cyc(); drive_lu(1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
            cyc(); hz.memRead_BF1 = 1'b0;
        end
        cyc(); hz.extStall_req = 1'b1;
        repeat (3) cyc();
        cyc(); hz.extStall_req = 1'b0;
        cyc(); #3;
        check("perf_stall", 32'(hz.stallCnt), 32'd6);
        check("perf_flush", 32'(hz.flushCnt), 32'd0);
`endif

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
